// File: rtl/wb_regfile.sv
// Write-back register file: 32 architectural integer registers with two
// combinational read ports, same-cycle write-to-read bypass and x0 tied to zero.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic [ADDR_W-1:0] wb_rd_addr,
  input  logic [DATA_W-1:0] wb_rd_val,
  input  logic [6:0]        wb_ins_type,
  input  logic              rs1_re,
  input  logic [ADDR_W-1:0] rs1_addr,
  output logic [DATA_W-1:0] rs1_val,
  input  logic              rs2_re,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [DATA_W-1:0] rs2_val
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_ALOPI = 7'b0010011;
  localparam logic [6:0] OP_ALOP  = 7'b0110011;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic              writesRd;
  logic              writeEn;

  // Only instruction classes that produce a destination value may commit.
  always_comb begin
    writesRd = 1'b0;
    case (wb_ins_type)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
      OP_LOAD, OP_ALOPI, OP_ALOP: writesRd = 1'b1;
      default:                    writesRd = 1'b0;
    endcase
  end

  assign writeEn = rdy_in & ~rst_in & (wb_rd_addr != '0) & writesRd;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else if (writeEn) begin
      regs_q[wb_rd_addr] <= wb_rd_val;
    end
  end

  // Bypass lets decode see a value retiring in the same cycle it is read.
  always_comb begin
    rs1_val = '0;
    if (!rst_in && rs1_re && (rs1_addr != '0)) begin
      if (writeEn && (rs1_addr == wb_rd_addr)) begin
        rs1_val = wb_rd_val;
      end else begin
        rs1_val = regs_q[rs1_addr];
      end
    end
  end

  always_comb begin
    rs2_val = '0;
    if (!rst_in && rs2_re && (rs2_addr != '0)) begin
      if (writeEn && (rs2_addr == wb_rd_addr)) begin
        rs2_val = wb_rd_val;
      end else begin
        rs2_val = regs_q[rs2_addr];
      end
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed testbench for wb_regfile: drives on the falling edge, checks
// combinational reads shortly after, and storage after the next rising edge.
module tb_wb_regfile;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_ALOPI  = 7'b0010011;
  localparam logic [6:0] OP_ALOP   = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_rd_val;
  logic [6:0]  wb_ins_type;
  logic        rs1_re;
  logic [4:0]  rs1_addr;
  logic [31:0] rs1_val;
  logic        rs2_re;
  logic [4:0]  rs2_addr;
  logic [31:0] rs2_val;

  int checks = 0;
  int errors = 0;

  wb_regfile dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .rdy_in      (rdy_in),
    .wb_rd_addr  (wb_rd_addr),
    .wb_rd_val   (wb_rd_val),
    .wb_ins_type (wb_ins_type),
    .rs1_re      (rs1_re),
    .rs1_addr    (rs1_addr),
    .rs1_val     (rs1_val),
    .rs2_re      (rs2_re),
    .rs2_addr    (rs2_addr),
    .rs2_val     (rs2_val)
  );

  always #10 clk_in = ~clk_in;

  task automatic drive_wb(input logic [6:0] op, input logic [4:0] rd, input logic [31:0] val);
    wb_ins_type = op;
    wb_rd_addr  = rd;
    wb_rd_val   = val;
  endtask

  task automatic drive_idle();
    drive_wb(OP_BRANCH, 5'd0, 32'h0);
  endtask

  task automatic test_reset();
    @(negedge clk_in);
    drive_wb(OP_ALOP, 5'd5, 32'hDEADBEEF);
    rs1_re = 1'b1; rs1_addr = 5'd5;
    @(negedge clk_in);
    drive_idle();
    #1;
    checks++;
    if (rs1_val !== 32'hDEADBEEF) begin
      errors++; $display("[TB] FAIL reset_prewrite: got %h expected %h", rs1_val, 32'hDEADBEEF);
    end
    #2 rst_in = 1'b1;
    #1;
    checks++;
    if (rs1_val !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_during: got %h expected %h", rs1_val, 32'h0);
    end
    #2 rst_in = 1'b0;
    #1;
    checks++;
    if (rs1_val !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_after_x5: got %h expected %h", rs1_val, 32'h0);
    end
    rs2_re = 1'b1;
    for (int a = 1; a < 32; a++) begin
      rs1_addr = 5'(a); rs2_addr = 5'(a);
      #1;
      checks++;
      if (rs1_val !== 32'h0 || rs2_val !== 32'h0) begin
        errors++; $display("[TB] FAIL reset_entry x%0d: got %h/%h expected 0", a, rs1_val, rs2_val);
      end
    end
    // reset held across a rising edge while a write is presented
    @(negedge clk_in);
    drive_wb(OP_ALOP, 5'd6, 32'hCAFEF00D);
    rs1_addr = 5'd6;
    rst_in = 1'b1;
    #1;
    checks++;
    if (rs1_val !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_midwrite_bypass: got %h expected %h", rs1_val, 32'h0);
    end
    @(negedge clk_in);
    rst_in = 1'b0;
    drive_idle();
    #1;
    checks++;
    if (rs1_val !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_midwrite_lost: got %h expected %h", rs1_val, 32'h0);
    end
  endtask

  task automatic test_basic();
    @(negedge clk_in);
    drive_wb(OP_ALOPI, 5'd7, 32'h12345678);
    @(negedge clk_in);
    drive_idle();
    rs1_re = 1'b1; rs1_addr = 5'd7;
    rs2_re = 1'b1; rs2_addr = 5'd7;
    #1;
    checks++;
    if (rs1_val !== 32'h12345678) begin
      errors++; $display("[TB] FAIL basic_rs1: got %h expected %h", rs1_val, 32'h12345678);
    end
    checks++;
    if (rs2_val !== 32'h12345678) begin
      errors++; $display("[TB] FAIL basic_rs2: got %h expected %h", rs2_val, 32'h12345678);
    end
    rs1_addr = 5'd8;
    #1;
    checks++;
    if (rs1_val !== 32'h0) begin
      errors++; $display("[TB] FAIL basic_x8: got %h expected %h", rs1_val, 32'h0);
    end
  endtask

  task automatic test_bypass();
    @(negedge clk_in);
    drive_wb(OP_LOAD, 5'd3, 32'hA5A5A5A5);
    rs2_re = 1'b1; rs2_addr = 5'd3;
    rs1_re = 1'b1; rs1_addr = 5'd7;
    #1;
    checks++;
    if (rs2_val !== 32'hA5A5A5A5) begin
      errors++; $display("[TB] FAIL bypass_rs2: got %h expected %h", rs2_val, 32'hA5A5A5A5);
    end
    checks++;
    if (rs1_val !== 32'h12345678) begin
      errors++; $display("[TB] FAIL bypass_other_port: got %h expected %h", rs1_val, 32'h12345678);
    end
    @(negedge clk_in);
    drive_idle();
    #1;
    checks++;
    if (rs2_val !== 32'hA5A5A5A5) begin
      errors++; $display("[TB] FAIL bypass_stored: got %h expected %h", rs2_val, 32'hA5A5A5A5);
    end
  endtask

  task automatic test_nonwrite();
    logic [6:0] ops [4];
    ops[0] = OP_STORE; ops[1] = OP_BRANCH; ops[2] = 7'b1111111; ops[3] = 7'b1110011;
    rs1_re = 1'b1; rs1_addr = 5'd4;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_in);
      drive_wb(ops[i], 5'd4, 32'(i + 1));
      #1;
      checks++;
      if (rs1_val !== 32'h0) begin
        errors++; $display("[TB] FAIL nonwrite_bypass op=%b: got %h expected %h", ops[i], rs1_val, 32'h0);
      end
    end
    @(negedge clk_in);
    drive_idle();
    #1;
    checks++;
    if (rs1_val !== 32'h0) begin
      errors++; $display("[TB] FAIL nonwrite_stored: got %h expected %h", rs1_val, 32'h0);
    end
  endtask

  task automatic test_opcodes();
    logic [6:0]  ops  [7];
    logic [31:0] vals [7];
    ops[0] = OP_LUI;  ops[1] = OP_AUIPC; ops[2] = OP_JAL; ops[3] = OP_JALR;
    ops[4] = OP_LOAD; ops[5] = OP_ALOPI; ops[6] = OP_ALOP;
    for (int i = 0; i < 7; i++) vals[i] = 32'h1000_0000 + 32'(i * 32'h0101);
    rs1_re = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk_in);
      drive_wb(ops[i], 5'(12 + i), vals[i]);
    end
    @(negedge clk_in);
    drive_idle();
    for (int i = 0; i < 7; i++) begin
      rs1_addr = 5'(12 + i);
      #1;
      checks++;
      if (rs1_val !== vals[i]) begin
        errors++; $display("[TB] FAIL opcode_write op=%b: got %h expected %h", ops[i], rs1_val, vals[i]);
      end
    end
  endtask

  task automatic test_x0_re();
    @(negedge clk_in);
    drive_wb(OP_JAL, 5'd0, 32'hFFFFFFFF);
    rs1_re = 1'b1; rs1_addr = 5'd0;
    rs2_re = 1'b1; rs2_addr = 5'd0;
    #1;
    checks++;
    if (rs1_val !== 32'h0 || rs2_val !== 32'h0) begin
      errors++; $display("[TB] FAIL x0_same_cycle: got %h/%h expected 0", rs1_val, rs2_val);
    end
    @(negedge clk_in);
    drive_wb(OP_ALOP, 5'd9, 32'h00000055);
    #1;
    checks++;
    if (rs1_val !== 32'h0) begin
      errors++; $display("[TB] FAIL x0_next_cycle: got %h expected %h", rs1_val, 32'h0);
    end
    @(negedge clk_in);
    drive_idle();
    rs1_re = 1'b0; rs1_addr = 5'd9;
    rs2_re = 1'b0; rs2_addr = 5'd9;
    #1;
    checks++;
    if (rs1_val !== 32'h0 || rs2_val !== 32'h0) begin
      errors++; $display("[TB] FAIL re_low: got %h/%h expected 0", rs1_val, rs2_val);
    end
    rs1_re = 1'b1;
    #1;
    checks++;
    if (rs1_val !== 32'h55 || rs2_val !== 32'h0) begin
      errors++; $display("[TB] FAIL re_high_x9: got %h/%h expected 00000055/00000000", rs1_val, rs2_val);
    end
  endtask

  task automatic test_stall();
    @(negedge clk_in);
    rdy_in = 1'b0;
    drive_wb(OP_AUIPC, 5'd10, 32'h77);
    rs1_re = 1'b1; rs1_addr = 5'd10;
    #1;
    checks++;
    if (rs1_val !== 32'h0) begin
      errors++; $display("[TB] FAIL stall_bypass: got %h expected %h", rs1_val, 32'h0);
    end
    @(negedge clk_in);
    #1;
    checks++;
    if (rs1_val !== 32'h0) begin
      errors++; $display("[TB] FAIL stall_frozen: got %h expected %h", rs1_val, 32'h0);
    end
    rdy_in = 1'b1;
    #1;
    checks++;
    if (rs1_val !== 32'h77) begin
      errors++; $display("[TB] FAIL stall_release_bypass: got %h expected %h", rs1_val, 32'h77);
    end
    @(negedge clk_in);
    drive_idle();
    #1;
    checks++;
    if (rs1_val !== 32'h77) begin
      errors++; $display("[TB] FAIL stall_release_stored: got %h expected %h", rs1_val, 32'h77);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk_in);
    drive_wb(OP_ALOP, 5'd11, 32'h00000111);
    rs1_re = 1'b1; rs1_addr = 5'd11;
    rs2_re = 1'b1; rs2_addr = 5'd11;
    @(negedge clk_in);
    drive_wb(OP_LUI, 5'd11, 32'h00000222);
    #1;
    checks++;
    if (rs1_val !== 32'h222 || rs2_val !== 32'h222) begin
      errors++; $display("[TB] FAIL b2b_bypass: got %h/%h expected 00000222", rs1_val, rs2_val);
    end
    @(negedge clk_in);
    drive_idle();
    #1;
    checks++;
    if (rs1_val !== 32'h222 || rs2_val !== 32'h222) begin
      errors++; $display("[TB] FAIL b2b_stored: got %h/%h expected 00000222", rs1_val, rs2_val);
    end
    rs1_addr = 5'd3; rs2_addr = 5'd7;
    #1;
    checks++;
    if (rs1_val !== 32'hA5A5A5A5 || rs2_val !== 32'h12345678) begin
      errors++; $display("[TB] FAIL b2b_others_held: got %h/%h expected a5a5a5a5/12345678", rs1_val, rs2_val);
    end
  endtask

  initial begin
    rst_in = 1'b1;
    rdy_in = 1'b1;
    drive_idle();
    rs1_re = 1'b0; rs1_addr = 5'd0;
    rs2_re = 1'b0; rs2_addr = 5'd0;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    test_reset();
    test_basic();
    test_bypass();
    test_nonwrite();
    test_opcodes();
    test_x0_re();
    test_stall();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
